// File: rtl/input_cond_pkg.sv
// Package shared by the input conditioner block.
// Holds the per-channel FSM state encoding, the default parameter values
// and a helper that sizes counters.
package input_cond_pkg;

  // Per-channel press state. RELEASED must stay at zero because reset and
  // the debug output both rely on "all zero" meaning "nothing pressed".
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } cond_state_t;

  localparam int DEF_WIDTH          = 4;
  localparam int DEF_SAMPLE_CNT_MAX = 25000;
  localparam int DEF_PULSE_CNT_MAX  = 200;
  localparam int DEF_HOLD_CNT_MAX   = 2000;
  localparam int DEF_REPEAT_CNT_MAX = 200;

  // Number of bits needed to hold every value in 0..max_value (at least 1).
  function automatic int cnt_bits(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/input_cond_channel.sv
// One conditioned input channel.
// Synchronizes a raw input, debounces it on the shared sample tick and runs
// the RELEASED/PRESSED/HELD state machine that produces the event pulses.
// Optional feature: define INPUT_COND_REPEAT_EN to emit auto-repeat press
// pulses while the channel is HELD.
//
// Ports:
//   i_clk      clock, all state on rising edge
//   i_rst_n    asynchronous active-low reset
//   i_tick     one-cycle sample strobe from the shared timer
//   i_in       raw asynchronous input
//   o_level    debounced level
//   o_press    one-cycle pulse on debounced rise (and on auto-repeat)
//   o_release  one-cycle pulse on debounced fall
//   o_hold     one-cycle pulse when the press has lasted HOLD_CNT_MAX ticks
//   o_state    current FSM state (debug visibility)
//
// Handshake: there is no valid/ready traffic here; o_press/o_release/o_hold
// are single-cycle strobes that a consumer must capture in the cycle they
// are high, there is no back-pressure.
module input_cond_channel
  import input_cond_pkg::*;
#(
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
  parameter int HOLD_CNT_MAX   = DEF_HOLD_CNT_MAX,
  parameter int REPEAT_CNT_MAX = DEF_REPEAT_CNT_MAX
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_tick,
  input  logic        i_in,
  output logic        o_level,
  output logic        o_press,
  output logic        o_release,
  output logic        o_hold,
  output cond_state_t o_state
);

  localparam int DIS_W  = cnt_bits(PULSE_CNT_MAX);
  localparam int HOLD_W = cnt_bits(HOLD_CNT_MAX);
  // The counters act on the edge where they would reach their limit, so the
  // compare value is one below the limit.
  localparam logic [DIS_W-1:0]  DIS_LAST  = DIS_W'(PULSE_CNT_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT_MAX - 1);

  if (PULSE_CNT_MAX < 1 || HOLD_CNT_MAX <= PULSE_CNT_MAX || REPEAT_CNT_MAX < 1)
  begin : g_bad_param
    $error("input_cond_channel: illegal counter parameters");
  end

  logic              r_sync1;
  logic              r_sync2;
  logic [DIS_W-1:0]  r_dis_cnt;
  logic              r_level;
  logic [HOLD_W-1:0] r_hold_cnt;
  cond_state_t       r_state;
  cond_state_t       w_state_nxt;
  logic              r_press;
  logic              r_release;
  logic              r_hold;

  logic w_differ;
  logic w_flip;
  logic w_rise;
  logic w_fall;
  logic w_hold_reach;
  logic w_rep_fire;
  logic w_press_nxt;
  logic w_release_nxt;
  logic w_hold_nxt;

  // Two-flop synchronizer; nothing downstream ever sees i_in directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differ = r_sync2 ^ r_level;
  // A flip happens on the tick where the run of disagreeing samples
  // completes; level toggles and the counter clears on that same edge.
  assign w_flip   = i_tick & w_differ & (r_dis_cnt == DIS_LAST);
  assign w_rise   = w_flip & ~r_level;
  assign w_fall   = w_flip & r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dis_cnt <= '0;
      r_level   <= 1'b0;
    end else if (i_tick) begin
      if (!w_differ || w_flip) begin
        r_dis_cnt <= '0;
      end else begin
        r_dis_cnt <= r_dis_cnt + 1'b1;
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
    end
  end

  // Hold counter: cleared on the rise edge (entry to PRESSED), counts ticks
  // only while PRESSED, so it stops at HOLD_CNT_MAX once HELD is reached.
  assign w_hold_reach = i_tick & (r_hold_cnt == HOLD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_rise) begin
      r_hold_cnt <= '0;
    end else if (r_state == PRESSED && i_tick) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

`ifdef INPUT_COND_REPEAT_EN
  localparam int REP_W = cnt_bits(REPEAT_CNT_MAX);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT_MAX - 1);

  logic [REP_W-1:0] r_rep_cnt;

  // A fall on the same tick wins: no repeat press is emitted on release.
  assign w_rep_fire = (r_state == HELD) & i_tick & ~w_fall & (r_rep_cnt == REP_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rep_cnt <= '0;
    end else if (r_state == PRESSED && w_state_nxt == HELD) begin
      r_rep_cnt <= '0;
    end else if (r_state == HELD && i_tick) begin
      r_rep_cnt <= w_rep_fire ? '0 : r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RELEASED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic. A debounced fall takes priority over reaching
  // the hold count on the same tick.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RELEASED: if (w_rise) w_state_nxt = PRESSED;
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt = RELEASED;
        end else if (w_hold_reach) begin
          w_state_nxt = HELD;
        end
      end
      HELD:     if (w_fall) w_state_nxt = RELEASED;
      default:  w_state_nxt = RELEASED;
    endcase
  end

  // FSM output logic; the pulses are registered so they appear in the cycle
  // after the tick that caused them.
  always_comb begin
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_hold_nxt    = 1'b0;
    unique case (r_state)
      RELEASED: w_press_nxt = w_rise;
      PRESSED: begin
        w_release_nxt = w_fall;
        w_hold_nxt    = w_hold_reach & ~w_fall;
      end
      HELD: begin
        w_release_nxt = w_fall;
        w_press_nxt   = w_rep_fire;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = r_hold;
  assign o_state   = r_state;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner (button debouncer with press/release/hold
// events). A single sample timer produces a tick shared by WIDTH identical,
// independent channels.
// Optional feature: define INPUT_COND_REPEAT_EN to enable auto-repeat press
// pulses while a channel is HELD.
//
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in         raw asynchronous inputs, one per channel
//   o_level      debounced level per channel
//   o_press      one-cycle pulse per channel on debounced rise / auto-repeat
//   o_release    one-cycle pulse per channel on debounced fall
//   o_hold       one-cycle pulse per channel once per long press
//   o_dbg_state  per-channel FSM state (debug visibility)
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
  parameter int HOLD_CNT_MAX   = DEF_HOLD_CNT_MAX,
  parameter int REPEAT_CNT_MAX = DEF_REPEAT_CNT_MAX
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic        [WIDTH-1:0]       i_in,
  output logic        [WIDTH-1:0]       o_level,
  output logic        [WIDTH-1:0]       o_press,
  output logic        [WIDTH-1:0]       o_release,
  output logic        [WIDTH-1:0]       o_hold,
  output cond_state_t [WIDTH-1:0]       o_dbg_state
);

  localparam int SMP_W = cnt_bits(SAMPLE_CNT_MAX - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CNT_MAX - 1);

  if (WIDTH < 1 || SAMPLE_CNT_MAX < 1) begin : g_bad_param
    $error("input_conditioner: WIDTH and SAMPLE_CNT_MAX must be >= 1");
  end

  logic [SMP_W-1:0] r_sample_cnt;
  logic             w_tick;

  // Free-running sample timer 0..SAMPLE_CNT_MAX-1; tick marks the last count.
  assign w_tick = (r_sample_cnt == SMP_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample_cnt <= '0;
    end else if (w_tick) begin
      r_sample_cnt <= '0;
    end else begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    input_cond_channel #(
      .PULSE_CNT_MAX  (PULSE_CNT_MAX),
      .HOLD_CNT_MAX   (HOLD_CNT_MAX),
      .REPEAT_CNT_MAX (REPEAT_CNT_MAX)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_tick    (w_tick),
      .i_in      (i_in[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_hold    (o_hold[g]),
      .o_state   (o_dbg_state[g])
    );
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, the number of independent input channels (>=1).
REQ-002 The module SHALL have parameter SAMPLE_CNT_MAX, default 25000, the clk cycles per sample tick (>=1).
REQ-003 The module SHALL have parameter PULSE_CNT_MAX, default 200, the consecutive disagreeing samples needed to change debounced level (>=1).
REQ-004 The module SHALL have parameter HOLD_CNT_MAX, default 2000, the sample ticks from press to hold pulse (>PULSE_CNT_MAX).
REQ-005 The module SHALL have parameter REPEAT_CNT_MAX, default 200, the sample ticks between auto-repeat press pulses (>=1).
REQ-006 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in  input  WIDTH  raw asynchronous inputs, e.g. buttons.
REQ-009 level  output  WIDTH  debounced level per channel.
REQ-010 press  output  WIDTH  one-cycle pulse on debounced rise, and on each auto-repeat.
REQ-011 release  output  WIDTH  one-cycle pulse on debounced fall.
REQ-012 hold  output  WIDTH  one-cycle pulse once per press after HOLD_CNT_MAX ticks.

Function
REQ-013 Each in bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 The shared sample timer SHALL count 0..SAMPLE_CNT_MAX-1 and wrap to 0, asserting tick for the single cycle in which it equals SAMPLE_CNT_MAX-1.
REQ-015 Each channel SHALL have a disagreement counter of width $clog2(PULSE_CNT_MAX+1), behaving as follows on tick:
- increment when the synchronized input differs from level;
- clear to 0 when the input agrees with level.
REQ-016 When the disagreement counter reaches PULSE_CNT_MAX on a tick, the channel SHALL:
- toggle level on that same edge;
- clear the counter;
- assert press (rise) or release (fall) in the following cycle, for exactly one cycle.
REQ-017 The per-channel FSM SHALL have states RELEASED, PRESSED and HELD:
- RELEASED->PRESSED on debounced rise;
- PRESSED->HELD when the hold counter reaches HOLD_CNT_MAX ticks, asserting hold for one cycle;
- PRESSED/HELD->RELEASED on debounced fall, with no hold or press emitted on that edge.
REQ-018 The hold counter SHALL clear on entry to PRESSED and increment only on tick, saturating in HELD.
REQ-019 Channels SHALL be fully independent, and simultaneous events on different channels SHALL each produce their own pulses in the same cycle.
REQ-020 Outside ticks, no counter except the sample timer SHALL change.

Reset
REQ-021 rst_n low SHALL immediately force the following, with no pulse emitted on reset deassertion:
- synchronizer flops, sample timer and all counters to 0;
- FSMs to RELEASED;
- level, press, release and hold to 0.
REQ-022 A reset during PRESSED or HELD SHALL discard the press, so that a still-held input re-debounces from zero after release of reset.

Configuration
REQ-023 With INPUT_COND_REPEAT_EN defined, a channel in HELD SHALL assert press for one cycle every REPEAT_CNT_MAX ticks after entering HELD, using a repeat counter cleared on HELD entry and on each repeat.
REQ-024 Without INPUT_COND_REPEAT_EN, the repeat counter SHALL not exist and press SHALL fire only on debounced rise.

Structure
REQ-025 Package input_cond_pkg SHALL hold the FSM state enum (RELEASED, PRESSED, HELD) and the default parameter constants.
REQ-026 The sub-module input_cond_channel SHALL contain the synchronizer, disagreement counter, FSM, and the hold and repeat counters, and SHALL be instantiated WIDTH times.
REQ-027 The sample timer SHALL reside in input_conditioner and SHALL be shared by all channels.

Verification (WIDTH=4, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, HOLD_CNT_MAX=8, REPEAT_CNT_MAX=2)
REQ-028 The bench SHALL cover a clean press: in[0]=1 held 20 ticks -> press[0] one cycle after the 3rd high tick, level[0]=1, hold[0] one cycle 8 ticks after rise, no further pulses.
REQ-029 The bench SHALL cover a glitch: in[1] high for 2 ticks then low -> level, press and hold stay 0, counter back to 0.
REQ-030 The bench SHALL cover a bouncy release: pressed in[2] dropped with one high sample among the lows -> release[2] only after 3 consecutive low ticks, exactly one pulse.
REQ-031 The bench SHALL cover reset mid-HELD: rst_n low for 1 cycle on ch3 in HELD -> all outputs 0 asynchronously, then re-press after 3 ticks with in[3] still 1.
REQ-032 The bench SHALL cover repeat with INPUT_COND_REPEAT_EN: hold in[0] 16 ticks -> press at ticks 0, 10, 12, 14, 16 relative to rise, hold at 8; without the macro -> press only at 0.
REQ-033 The bench SHALL cover simultaneity: in[3:0]=4'b1111 in one cycle -> press=4'b1111 in the same cycle, later release=4'b1111 together.
